serial_mag_comp_ctrl: RTL
=========================

Name: serial_mag_comp_ctrl

Overview:
- Bit-serial magnitude comparator controller for W-bit operands.
- Latches A and B on a start request, then compares one bit pair per cycle, MSB first, using a single 1-bit compare stage.
- Stops at the first differing bit; otherwise finishes after all W bits.
- Reports the one-hot 3-bit result with the team's comparator encoding: 100 = A<B, 010 = A==B, 001 = A>B. Hands results to sequencing logic with a start/done handshake.

Parameters:
W, 8, operand width in bits (W >= 2).
CW, $clog2(W+1), width of the bit-count output.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request a comparison; honoured only in IDLE.
a  input  W  operand A; sampled only on the edge that accepts start.
b  input  W  operand B; sampled only on the edge that accepts start.
busy  output  1  high while state is not IDLE.
done  output  1  single-cycle pulse; result and nbits are valid in this cycle.
result  output  3  one-hot compare result: 100 lt, 010 eq, 001 gt; 000 after reset.
nbits  output  CW  number of bit pairs examined by the last comparison (1..W).

Behaviour:
- States: IDLE, SCAN, DONE. Encoding is free; busy = (state != IDLE).
- Reset, when rst_n is low at a clock edge:
  - state goes to IDLE.
  - busy=0, done=0, result=000, nbits=0.
  - Internal operand registers and bit index are cleared.
  - Reset overrides all other inputs, including start in the same cycle.
- IDLE:
  - On an edge with start=1, latch a_q<=a, b_q<=b and idx<=W-1, then go to SCAN.
  - start=0 keeps the block in IDLE.
  - result and nbits hold their previous values.
- SCAN, one bit pair per cycle:
  - Compare a_q[idx] with b_q[idx].
  - If a_q[idx] != b_q[idx]: at the edge, result <= (a bit 1) ? 001 : 100, nbits <= W-idx, go to DONE.
  - Else if idx == 0: result <= 010, nbits <= W, go to DONE.
  - Else idx <= idx-1 and stay in SCAN.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - Start is accepted at edge T and the deciding bit is examined n cycles after it.
  - done is high in the cycle following edge T+n, where n = nbits.
  - MSB differs: done after edge T+1. Fully equal operands: done after edge T+W.
- start while busy (SCAN or DONE) is ignored. It is not queued and does not disturb a_q, b_q or idx.
- Earliest re-accept is the edge ending the IDLE cycle after DONE. Throughput is at most one comparison per n+2 cycles.
- Changes on a/b while busy have no effect.
- result/nbits change only on the deciding edge; they are stable from done through the next deciding edge.
- Reset mid-SCAN aborts the comparison with no done pulse; result returns to 000.
- Unsigned compare only.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, result=000, nbits=0; no comparison starts.
- MSB difference: a=8'h80, b=8'h7F, start one cycle -> done one cycle after edge T+1, result=001, nbits=1; busy high exactly 2 cycles.
- LSB difference: a=8'h12, b=8'h13 -> result=100, nbits=8, done after edge T+8; then a=8'h13, b=8'h12 -> result=001, nbits=8.
- Equality: a=b=8'hA5 -> result=010, nbits=8. Then a=b=8'h00 -> result=010 and done re-pulses.
- Ignored start: launch a=8'h0F, b=8'hF0. Pulse start with a=8'hFF, b=8'h00 at SCAN cycle 1 and again during DONE -> result=100, nbits=1, exactly one done pulse. A new start in the following IDLE is accepted.
- Reset mid-op: a=8'h01, b=8'h01, assert rst_n=0 during the 4th SCAN cycle -> no done pulse, result=000, busy=0 next cycle. A subsequent start with a=8'h03, b=8'h02 gives result=001, nbits=8.

Source files
------------

// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator, MSB first.
// Result is one-hot: 100 lt, 010 eq, 001 gt.
module serial_mag_comp_ctrl #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [2:0]    result,
    output logic [CW-1:0] nbits
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx, idx_d;
    logic [2:0]    result_d;
    logic [CW-1:0] nbits_d;
    logic          abit, bbit;

    assign abit = a_q[idx];
    assign bbit = b_q[idx];
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            result <= 3'b000;
            nbits  <= '0;
        end else begin
            state  <= state_d;
            a_q    <= a_d;
            b_q    <= b_d;
            idx    <= idx_d;
            result <= result_d;
            nbits  <= nbits_d;
        end
    end

    always_comb begin
        state_d  = state;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx;
        result_d = result;
        nbits_d  = nbits;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(W - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abit != bbit) begin
                    result_d = abit ? 3'b001 : 3'b100;
                    nbits_d  = CW'(W) - CW'(idx);
                    state_d  = FIN;
                end else if (idx == '0) begin
                    result_d = 3'b010;
                    nbits_d  = CW'(W);
                    state_d  = FIN;
                end else begin
                    idx_d = idx - IW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
